// File: rtl/regfile_wb_scheduler_if.sv
// Writeback/reservation bundle between the issue, execute and memory stages and the
// writeback scheduler. The scheduler uses the slave view.
interface regfile_wb_scheduler_if #(
  parameter int NUM_REQ    = 3,
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADD_WIDTH-1:0]  req_rd;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          rsv_valid;
  logic [ADD_WIDTH-1:0]          rsv_rd;
  logic                          rsv_ready;
  logic [(2**ADD_WIDTH)-1:0]     busy;
  logic                          regwrite;
  logic [ADD_WIDTH-1:0]          add_rd;
  logic [DATA_WIDTH-1:0]         write_data;

  modport slave (
    input  req_valid, req_rd, req_data, rsv_valid, rsv_rd,
    output req_ready, rsv_ready, busy, regwrite, add_rd, write_data
  );

  modport master (
    output req_valid, req_rd, req_data, rsv_valid, rsv_rd,
    input  req_ready, rsv_ready, busy, regwrite, add_rd, write_data
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin scheduler for the single regfile write port, with a one-bit-per-register
// busy scoreboard that the issue stage sets and committed writes clear.
module regfile_wb_scheduler #(
  parameter int NUM_REQ    = 3,
  parameter int ADD_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_scheduler_if.slave  wb
);
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REG = 2**ADD_WIDTH;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_s;
  logic                  accept_s;
  logic [ADD_WIDTH-1:0]  win_rd_s;
  logic [DATA_WIDTH-1:0] win_data_s;
  logic                  rsv_ready_s;
  logic [NUM_REG-1:0]    busy_q, busy_d;
  logic                  regwrite_q;
  logic [ADD_WIDTH-1:0]  add_rd_q;
  logic [DATA_WIDTH-1:0] write_data_q;

  // Round-robin search starting just above the last winner, wrapping at NUM_REQ.
  always_comb begin
    int               sum;
    logic [PTR_W-1:0] idx;
    sum        = 0;
    idx        = '0;
    grant_s    = '0;
    accept_s   = 1'b0;
    ptr_d      = ptr_q;
    win_rd_s   = '0;
    win_data_s = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(ptr_q) + k;
      idx = (sum >= NUM_REQ) ? PTR_W'(sum - NUM_REQ) : PTR_W'(sum);
      if (!accept_s && wb.req_valid[idx]) begin
        accept_s     = 1'b1;
        grant_s[idx] = 1'b1;
        ptr_d        = idx;
        win_rd_s     = wb.req_rd[idx*ADD_WIDTH +: ADD_WIDTH];
        win_data_s   = wb.req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        accept_s = accept_s;
      end
    end
  end

  // Scoreboard next state: a committing write clears, an accepted reservation sets.
  always_comb begin
    rsv_ready_s = !busy_q[wb.rsv_rd];
    busy_d      = busy_q;
    if (regwrite_q) begin
      busy_d[add_rd_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (wb.rsv_valid && rsv_ready_s) begin
      busy_d[wb.rsv_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Pointer, scoreboard and the one-cycle write stage toward the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= PTR_W'(NUM_REQ - 1);
      busy_q       <= '0;
      regwrite_q   <= 1'b0;
      add_rd_q     <= '0;
      write_data_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      if (accept_s) begin
        regwrite_q   <= (win_rd_s != '0);
        add_rd_q     <= win_rd_s;
        write_data_q <= win_data_s;
      end else begin
        regwrite_q   <= 1'b0;
      end
    end
  end

  assign wb.req_ready  = grant_s;
  assign wb.rsv_ready  = rsv_ready_s;
  assign wb.busy       = busy_q;
  assign wb.regwrite   = regwrite_q;
  assign wb.add_rd     = add_rd_q;
  assign wb.write_data = write_data_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus a randomized phase, all
// checked against a behavioural model of the scheduling and scoreboard rules.
module tb_regfile_wb_scheduler;
  localparam int NR = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_wb_scheduler_if #(.NUM_REQ(NR), .ADD_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_scheduler #(.NUM_REQ(NR), .ADD_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // requester / issue-stage stimulus state
  logic        v_r   [NR];
  logic [4:0]  rd_r  [NR];
  logic [31:0] dat_r [NR];
  logic        rv_r;
  logic [4:0]  rr_r;

  // reference model
  int          m_ptr;
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  int          last_g;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = NR - 1;
    m_wr   = 1'b0;
    m_rd   = 5'd0;
    m_data = 32'd0;
    m_busy = 32'd0;
  endtask

  task automatic stim_clear();
    for (int i = 0; i < NR; i++) begin
      v_r[i]   = 1'b0;
      rd_r[i]  = 5'd0;
      dat_r[i] = 32'd0;
    end
    rv_r = 1'b0;
    rr_r = 5'd0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = v_r[i];
      bus.req_rd[i*AW +: AW]      = rd_r[i];
      bus.req_data[i*DW +: DW]    = dat_r[i];
    end
    bus.rsv_valid = rv_r;
    bus.rsv_rd    = rr_r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stim_clear();
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check registered outputs, apply inputs, check the combinational
  // handshakes, then advance the model across the coming posedge.
  task automatic cycle();
    logic [2:0]  exp_grant;
    logic [31:0] nb;
    @(negedge clk);
    check_val("regwrite", bus.regwrite, m_wr);
    check_val("add_rd", bus.add_rd, m_rd);
    check_val("write_data", bus.write_data, m_data);
    check_val("busy", bus.busy, m_busy);
    drive();
    #1;
    last_g = -1;
    for (int k = 1; k <= NR; k++) begin
      if (last_g < 0 && v_r[(m_ptr + k) % NR]) last_g = (m_ptr + k) % NR;
    end
    exp_grant = 3'b000;
    if (last_g >= 0) exp_grant[last_g] = 1'b1;
    check_val("req_ready", bus.req_ready, exp_grant);
    check_val("rsv_ready", bus.rsv_ready, !m_busy[rr_r]);
    nb = m_busy;
    if (m_wr) nb[m_rd] = 1'b0;
    if (rv_r && !m_busy[rr_r]) nb[rr_r] = 1'b1;
    nb[0]  = 1'b0;
    m_busy = nb;
    if (last_g >= 0) begin
      m_wr   = (rd_r[last_g] != 5'd0);
      m_rd   = rd_r[last_g];
      m_data = dat_r[last_g];
      m_ptr  = last_g;
    end else begin
      m_wr = 1'b0;
    end
  endtask

  logic [2:0] exp_seq [6];

  initial begin
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
    exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;

    do_reset();
    check_val("rst_regwrite", bus.regwrite, 1'b0);
    check_val("rst_busy", bus.busy, 32'd0);

    // single write after reset, one-cycle latency
    stim_clear();
    v_r[0] = 1'b1; rd_r[0] = 5'd6; dat_r[0] = 32'h2;
    cycle();
    check_val("t1_grant", bus.req_ready, 3'b001);
    stim_clear();
    cycle();
    check_val("t1_wr", bus.regwrite, 1'b1);
    check_val("t1_rd", bus.add_rd, 5'd6);
    check_val("t1_data", bus.write_data, 32'h2);
    cycle();
    check_val("t1_idle", bus.regwrite, 1'b0);

    // all three requesting: strict rotation
    do_reset();
    stim_clear();
    for (int i = 0; i < NR; i++) begin
      v_r[i] = 1'b1; rd_r[i] = 5'(10 + i); dat_r[i] = 32'(100 + i);
    end
    for (int c = 0; c < 6; c++) begin
      cycle();
      check_val($sformatf("t2_grant%0d", c), bus.req_ready, exp_seq[c]);
      rd_r[last_g]  = 5'(13 + c);
      dat_r[last_g] = 32'(200 + c);
    end
    stim_clear();
    cycle();
    check_val("t2_last_wr", bus.regwrite, 1'b1);

    // reservation, WAW stall, clear on commit
    stim_clear();
    cycle();
    rv_r = 1'b1; rr_r = 5'd7;
    cycle();
    cycle();
    check_val("t3_stall", bus.rsv_ready, 1'b0);
    check_val("t3_busy7", bus.busy[7], 1'b1);
    stim_clear();
    v_r[1] = 1'b1; rd_r[1] = 5'd7; dat_r[1] = 32'h77;
    cycle();
    stim_clear();
    rv_r = 1'b1; rr_r = 5'd7;
    cycle();
    check_val("t3_pending_stall", bus.rsv_ready, 1'b0);
    stim_clear();
    cycle();
    check_val("t3_cleared", bus.busy[7], 1'b0);
    rv_r = 1'b1; rr_r = 5'd7;
    cycle();
    check_val("t3_rsv_ok", bus.rsv_ready, 1'b1);

    // x0 writes and reservations are no-ops
    stim_clear();
    v_r[0] = 1'b1; rd_r[0] = 5'd0; dat_r[0] = 32'hFFFF_FFFF;
    rv_r = 1'b1; rr_r = 5'd0;
    cycle();
    check_val("t4_rsv_ready", bus.rsv_ready, 1'b1);
    check_val("t4_req_ready", bus.req_ready[0], 1'b1);
    stim_clear();
    cycle();
    check_val("t4_no_write", bus.regwrite, 1'b0);
    check_val("t4_busy0", bus.busy[0], 1'b0);

    // async reset during an active write
    do_reset();
    stim_clear();
    v_r[2] = 1'b1; rd_r[2] = 5'd5; dat_r[2] = 32'h55;
    rv_r = 1'b1; rr_r = 5'd5;
    cycle();
    @(negedge clk);
    check_val("t5_pre_wr", bus.regwrite, 1'b1);
    check_val("t5_pre_busy5", bus.busy[5], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_rst_wr", bus.regwrite, 1'b0);
    check_val("t5_rst_busy", bus.busy, 32'd0);
    do_reset();
    stim_clear();
    for (int i = 0; i < NR; i++) begin
      v_r[i] = 1'b1; rd_r[i] = 5'(20 + i); dat_r[i] = 32'(i);
    end
    cycle();
    check_val("t5_first_win", bus.req_ready, 3'b001);

    // same-edge clear of reg 5 and set of reg 9
    stim_clear();
    rv_r = 1'b1; rr_r = 5'd5;
    cycle();
    stim_clear();
    v_r[1] = 1'b1; rd_r[1] = 5'd5; dat_r[1] = 32'hA5;
    cycle();
    stim_clear();
    rv_r = 1'b1; rr_r = 5'd9;
    cycle();
    check_val("t6_wr5", bus.regwrite, 1'b1);
    stim_clear();
    cycle();
    check_val("t6_busy5", bus.busy[5], 1'b0);
    check_val("t6_busy9", bus.busy[9], 1'b1);

    // randomized traffic
    stim_clear();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!v_r[i] && ($urandom_range(0, 1) == 1)) begin
          v_r[i]   = 1'b1;
          rd_r[i]  = 5'($urandom_range(0, 31));
          dat_r[i] = $urandom;
        end
      end
      rv_r = ($urandom_range(0, 2) == 0);
      rr_r = 5'($urandom_range(0, 31));
      cycle();
      if (last_g >= 0) v_r[last_g] = 1'b0;
    end
    stim_clear();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
